// File: rtl/sap1_sequencer.sv
// sap1_sequencer: variable-length T-state sequencer for the SAP-1 datapath.
// Drives the 16-bit shared-bus control word, gates execution with run/stall,
// holds a sticky halt and counts retired instructions.
// Optional build macro SAP1_STEP_EN adds a synchronised single-step button input.
module sap1_sequencer #(
    parameter int CW_W  = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       opcode,
    input  logic             flag_c,
    input  logic             flag_z,
    input  logic             run,
    input  logic             stall,
`ifdef SAP1_STEP_EN
    input  logic             step,
`endif
    output logic [CW_W-1:0]  ctrl,
    output logic [2:0]       tstate,
    output logic             halted,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_count
);

    // Control word bit positions
    localparam logic [CW_W-1:0] HLT       = CW_W'(16'h8000);
    localparam logic [CW_W-1:0] PC_INC    = CW_W'(16'h4000);
    localparam logic [CW_W-1:0] PC_EN     = CW_W'(16'h2000);
    localparam logic [CW_W-1:0] MAR_LOAD  = CW_W'(16'h1000);
    localparam logic [CW_W-1:0] MEM_EN    = CW_W'(16'h0800);
    localparam logic [CW_W-1:0] IR_LOAD   = CW_W'(16'h0400);
    localparam logic [CW_W-1:0] IR_EN     = CW_W'(16'h0200);
    localparam logic [CW_W-1:0] A_LOAD    = CW_W'(16'h0100);
    localparam logic [CW_W-1:0] A_EN      = CW_W'(16'h0080);
    localparam logic [CW_W-1:0] B_LOAD    = CW_W'(16'h0040);
    localparam logic [CW_W-1:0] ADDER_SUB = CW_W'(16'h0020);
    localparam logic [CW_W-1:0] ACC_LOAD  = CW_W'(16'h0008);
    localparam logic [CW_W-1:0] PC_LOAD   = CW_W'(16'h0004);
    localparam logic [CW_W-1:0] MEM_WE    = CW_W'(16'h0002);
    localparam logic [CW_W-1:0] OUT_LOAD  = CW_W'(16'h0001);

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_STA = 4'h3;
    localparam logic [3:0] OP_LDI = 4'h4;
    localparam logic [3:0] OP_JMP = 4'h5;
    localparam logic [3:0] OP_JC  = 4'h6;
    localparam logic [3:0] OP_JZ  = 4'h7;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4,
        T5 = 3'd5
    } tstate_e;

    tstate_e          state_q, state_d, state_nxt;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CW_W-1:0]  word;
    logic             last;
    logic             adv;
    logic             step_pulse;

`ifdef SAP1_STEP_EN
    logic [2:0] step_sync_q;

    // Two-flop synchroniser for the step button plus one history flop for edge detection
    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            step_sync_q <= '0;
        end else begin
            step_sync_q <= {step_sync_q[1:0], step};
        end
    end

    assign step_pulse = step_sync_q[1] & ~step_sync_q[2];
`else
    assign step_pulse = 1'b0;
`endif

    assign adv = (run | step_pulse) & ~stall & ~halted_q;

    // Sequencer state, halt flag and retired-instruction counter
    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= T0;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
        end
    end

    // Microcode decode, last-state detection and next-state selection
    always_comb begin
        word      = '0;
        last      = 1'b0;
        state_nxt = T0;
        case (state_q)
            T0: begin
                word      = PC_EN | MAR_LOAD;
                state_nxt = T1;
            end
            T1: begin
                word      = PC_INC;
                state_nxt = T2;
            end
            T2: begin
                word      = MEM_EN | IR_LOAD;
                state_nxt = T3;
            end
            T3: begin
                state_nxt = T4;
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: word = IR_EN | MAR_LOAD;
                    OP_LDI: begin
                        word = IR_EN | A_LOAD;
                        last = 1'b1;
                    end
                    OP_JMP: begin
                        word = IR_EN | PC_LOAD;
                        last = 1'b1;
                    end
                    OP_JC: begin
                        word = flag_c ? (IR_EN | PC_LOAD) : '0;
                        last = 1'b1;
                    end
                    OP_JZ: begin
                        word = flag_z ? (IR_EN | PC_LOAD) : '0;
                        last = 1'b1;
                    end
                    OP_OUT: begin
                        word = A_EN | OUT_LOAD;
                        last = 1'b1;
                    end
                    OP_HLT: begin
                        word = HLT;
                        last = 1'b1;
                    end
                    default: last = 1'b1;
                endcase
            end
            T4: begin
                state_nxt = T5;
                case (opcode)
                    OP_LDA: begin
                        word = MEM_EN | A_LOAD;
                        last = 1'b1;
                    end
                    OP_ADD, OP_SUB: word = MEM_EN | B_LOAD;
                    OP_STA: begin
                        word = A_EN | MEM_WE;
                        last = 1'b1;
                    end
                    // An opcode that changed mid-instruction falls back to fetch
                    default: last = 1'b1;
                endcase
            end
            T5: begin
                last = 1'b1;
                case (opcode)
                    OP_ADD:  word = ACC_LOAD;
                    OP_SUB:  word = ACC_LOAD | ADDER_SUB;
                    default: word = '0;
                endcase
            end
            default: last = 1'b1;
        endcase
    end

    // Advance/hold decision, halt capture and retirement counting
    always_comb begin
        state_d  = state_q;
        halted_d = halted_q;
        cnt_d    = cnt_q;
        if (adv) begin
            if (last) begin
                state_d = T0;
                cnt_d   = cnt_q + CNT_W'(1);
                if (state_q == T3 && opcode == OP_HLT) begin
                    halted_d = 1'b1;
                end
            end else begin
                state_d = state_nxt;
            end
        end
    end

    assign ctrl        = halted_q ? HLT : (word & {CW_W{adv}});
    assign tstate      = state_q;
    assign halted      = halted_q;
    assign instr_done  = adv & last;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_sap1_sequencer.sv
// Testbench for sap1_sequencer: vector table, directed corner sequences and
// randomized run/stall/opcode traffic against an instruction-level model.
module tb_sap1_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  opcode;
    logic        flag_c;
    logic        flag_z;
    logic        run;
    logic        stall;
`ifdef SAP1_STEP_EN
    logic        step;
`endif
    logic [15:0] ctrl;
    logic [2:0]  tstate;
    logic        halted;
    logic        instr_done;
    logic [7:0]  instr_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sap1_sequencer #(.CW_W(16), .CNT_W(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .opcode     (opcode),
        .flag_c     (flag_c),
        .flag_z     (flag_z),
        .run        (run),
        .stall      (stall),
`ifdef SAP1_STEP_EN
        .step       (step),
`endif
        .ctrl       (ctrl),
        .tstate     (tstate),
        .halted     (halted),
        .instr_done (instr_done),
        .instr_count(instr_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- instruction-level reference model ----------------
    int   m_t;
    logic m_halt;
    int   m_cnt;

    function automatic int last_of(input logic [3:0] op);
        case (op)
            4'h0, 4'h3: return 4;
            4'h1, 4'h2: return 5;
            default:    return 3;
        endcase
    endfunction

    function automatic logic [15:0] word_of(input int t, input logic [3:0] op,
                                            input logic c, input logic z);
        if (t == 0) return 16'h3000;
        if (t == 1) return 16'h4000;
        if (t == 2) return 16'h0C00;
        if (t == 3) begin
            case (op)
                4'h0, 4'h1, 4'h2, 4'h3: return 16'h1200;
                4'h4: return 16'h0300;
                4'h5: return 16'h0204;
                4'h6: return c ? 16'h0204 : 16'h0000;
                4'h7: return z ? 16'h0204 : 16'h0000;
                4'hE: return 16'h0081;
                4'hF: return 16'h8000;
                default: return 16'h0000;
            endcase
        end
        if (t == 4) begin
            case (op)
                4'h0:       return 16'h0900;
                4'h1, 4'h2: return 16'h0840;
                4'h3:       return 16'h0082;
                default:    return 16'h0000;
            endcase
        end
        if (op == 4'h1) return 16'h0008;
        if (op == 4'h2) return 16'h0028;
        return 16'h0000;
    endfunction

    function automatic logic m_adv();
        return run & ~stall & ~m_halt;
    endfunction

    function automatic logic [15:0] m_ctrl();
        if (m_halt) return 16'h8000;
        return m_adv() ? word_of(m_t, opcode, flag_c, flag_z) : 16'h0000;
    endfunction

    always @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_t    <= 0;
            m_halt <= 1'b0;
            m_cnt  <= 0;
        end else if (m_adv()) begin
            if (m_t == last_of(opcode)) begin
                m_t   <= 0;
                m_cnt <= (m_cnt + 1) % 256;
                if (opcode == 4'hF) m_halt <= 1'b1;
            end else begin
                m_t <= m_t + 1;
            end
        end
    end

    task automatic compare_model(input int cyc);
        chk($sformatf("rnd%0d_ctrl", cyc), ctrl, m_ctrl());
        chk($sformatf("rnd%0d_tstate", cyc), tstate, m_t);
        chk($sformatf("rnd%0d_halted", cyc), halted, m_halt);
        chk($sformatf("rnd%0d_done", cyc), instr_done, m_adv() && (m_t == last_of(opcode)));
        chk($sformatf("rnd%0d_count", cyc), instr_count, m_cnt);
    endtask

    // At most one bus driver per word; fetch T1 and gated words drive nothing
    always @(posedge clk) begin
        if (reset_n) begin
            assert ($countones(ctrl & 16'h2A90) <= 1)
            else begin
                errors++;
                $display("FAIL bus_driver: ctrl %0h enables %0d drivers", ctrl, $countones(ctrl & 16'h2A90));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [3:0]  op;
        logic        c;
        logic        z;
        int          len;
        logic [15:0] w3;
        logic [15:0] w4;
        logic [15:0] w5;
    } vec_t;

    vec_t        vecs [12];
    logic [15:0] fetch_w [3];
    logic [15:0] exp_w;
    int          exp_cnt;
    int          inc_seen;

    task automatic next_edge();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #3;
        chk("rst_tstate", tstate, 0);
        chk("rst_halted", halted, 0);
        chk("rst_count", instr_count, 0);
        reset_n = 1'b1;
    endtask

    initial begin
        fetch_w[0] = 16'h3000;
        fetch_w[1] = 16'h4000;
        fetch_w[2] = 16'h0C00;
        vecs[0]  = '{4'h0, 1'b0, 1'b0, 5, 16'h1200, 16'h0900, 16'h0000};
        vecs[1]  = '{4'h1, 1'b0, 1'b0, 6, 16'h1200, 16'h0840, 16'h0008};
        vecs[2]  = '{4'h2, 1'b0, 1'b0, 6, 16'h1200, 16'h0840, 16'h0028};
        vecs[3]  = '{4'h3, 1'b0, 1'b0, 5, 16'h1200, 16'h0082, 16'h0000};
        vecs[4]  = '{4'h4, 1'b0, 1'b0, 4, 16'h0300, 16'h0000, 16'h0000};
        vecs[5]  = '{4'h5, 1'b0, 1'b0, 4, 16'h0204, 16'h0000, 16'h0000};
        vecs[6]  = '{4'h6, 1'b0, 1'b0, 4, 16'h0000, 16'h0000, 16'h0000};
        vecs[7]  = '{4'h6, 1'b1, 1'b0, 4, 16'h0204, 16'h0000, 16'h0000};
        vecs[8]  = '{4'h7, 1'b1, 1'b0, 4, 16'h0000, 16'h0000, 16'h0000};
        vecs[9]  = '{4'h7, 1'b0, 1'b1, 4, 16'h0204, 16'h0000, 16'h0000};
        vecs[10] = '{4'hE, 1'b0, 1'b0, 4, 16'h0081, 16'h0000, 16'h0000};
        vecs[11] = '{4'h9, 1'b0, 1'b0, 4, 16'h0000, 16'h0000, 16'h0000};

        reset_n = 1'b0;
        run     = 1'b0;
        stall   = 1'b0;
        opcode  = 4'h0;
        flag_c  = 1'b0;
        flag_z  = 1'b0;
`ifdef SAP1_STEP_EN
        step    = 1'b0;
`endif
        #2;
        chk("reset_ctrl", ctrl, 16'h0000);
        chk("reset_tstate", tstate, 0);
        chk("reset_halted", halted, 0);
        chk("reset_count", instr_count, 0);
        next_edge();
        next_edge();
        chk("reset_hold_tstate", tstate, 0);
        reset_n = 1'b1;
        run     = 1'b1;

        // Table of single instructions, free-running
        exp_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            opcode = vecs[i].op;
            flag_c = vecs[i].c;
            flag_z = vecs[i].z;
            for (int t = 0; t < vecs[i].len; t++) begin
                @(posedge clk);
                if (t < 3)       exp_w = fetch_w[t];
                else if (t == 3) exp_w = vecs[i].w3;
                else if (t == 4) exp_w = vecs[i].w4;
                else             exp_w = vecs[i].w5;
                chk($sformatf("v%0d_t%0d_ctrl", i, t), ctrl, exp_w);
                chk($sformatf("v%0d_t%0d_tstate", i, t), tstate, t);
                chk($sformatf("v%0d_t%0d_done", i, t), instr_done, (t == vecs[i].len - 1));
                next_edge();
            end
            exp_cnt++;
            chk($sformatf("v%0d_end_tstate", i), tstate, 0);
            chk($sformatf("v%0d_count", i), instr_count, exp_cnt);
        end

        // Stall held for 10 clocks in T1
        opcode = 4'h0;
        inc_seen = 0;
        @(posedge clk);
        chk("stall_t0_ctrl", ctrl, 16'h3000);
        next_edge();
        stall = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            chk($sformatf("stall%0d_ctrl", k), ctrl, 16'h0000);
            chk($sformatf("stall%0d_tstate", k), tstate, 1);
            if (ctrl[14]) inc_seen++;
            next_edge();
        end
        stall = 1'b0;
        @(posedge clk);
        chk("unstall_ctrl", ctrl, 16'h4000);
        chk("unstall_tstate", tstate, 1);
        if (ctrl[14]) inc_seen++;
        next_edge();
        @(posedge clk);
        chk("unstall_t2_tstate", tstate, 2);
        chk("unstall_t2_ctrl", ctrl, 16'h0C00);
        if (ctrl[14]) inc_seen++;
        chk("stall_pc_inc_once", inc_seen, 1);
        next_edge();
        for (int k = 0; k < 10 && tstate != 0; k++) next_edge();
        chk("stall_instr_end", tstate, 0);
        exp_cnt++;
        chk("stall_count", instr_count, exp_cnt);

        // Randomized run/stall/flags with a fresh opcode at each fetch
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (m_t == 0) opcode = 4'($urandom_range(0, 14));
            run    = ($urandom_range(0, 9) != 0);
            stall  = ($urandom_range(0, 4) == 0);
            flag_c = 1'($urandom_range(0, 1));
            flag_z = 1'($urandom_range(0, 1));
            @(posedge clk);
            compare_model(cyc);
            next_edge();
        end

        // Counter wrap over 256 LDI instructions
        run   = 1'b1;
        stall = 1'b0;
        do_reset();
        opcode = 4'h4;
        for (int k = 0; k < 255 * 4; k++) next_edge();
        chk("wrap_255", instr_count, 255);
        for (int k = 0; k < 4; k++) next_edge();
        chk("wrap_0", instr_count, 0);
        chk("wrap_tstate", tstate, 0);

        // Halt: sticky HLT word, then asynchronous reset mid-cycle
        opcode = 4'hF;
        for (int k = 0; k < 3; k++) next_edge();
        @(posedge clk);
        chk("hlt_t3_ctrl", ctrl, 16'h8000);
        chk("hlt_t3_tstate", tstate, 3);
        chk("hlt_t3_done", instr_done, 1);
        chk("hlt_t3_halted", halted, 0);
        next_edge();
        chk("hlt_halted", halted, 1);
        chk("hlt_tstate", tstate, 0);
        chk("hlt_count", instr_count, 1);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            chk($sformatf("hlt_hold%0d_ctrl", k), ctrl, 16'h8000);
            chk($sformatf("hlt_hold%0d_tstate", k), tstate, 0);
            chk($sformatf("hlt_hold%0d_done", k), instr_done, 0);
        end
        run = 1'b0;
        @(posedge clk);
        chk("hlt_run0_ctrl", ctrl, 16'h8000);
        #2;
        reset_n = 1'b0;
        #1;
        chk("hlt_rst_ctrl", ctrl, 16'h0000);
        chk("hlt_rst_halted", halted, 0);
        chk("hlt_rst_tstate", tstate, 0);
        chk("hlt_rst_count", instr_count, 0);
        chk("hlt_rst_done", instr_done, 0);
        next_edge();
        reset_n = 1'b1;
        opcode  = 4'h0;

`ifdef SAP1_STEP_EN
        // Single-step with run=0: each step rise advances one T-state on the third edge
        for (int p = 0; p < 3; p++) begin
            step = 1'b1;
            next_edge();
            chk($sformatf("step%0d_e1", p), tstate, p);
            next_edge();
            chk($sformatf("step%0d_e2", p), tstate, p);
            next_edge();
            chk($sformatf("step%0d_e3", p), tstate, p + 1);
            next_edge();
            chk($sformatf("step%0d_e4", p), tstate, p + 1);
            step = 1'b0;
            for (int k = 0; k < 3; k++) next_edge();
            chk($sformatf("step%0d_idle", p), tstate, p + 1);
        end
        chk("step_final_tstate", tstate, 3);
        chk("step_count", instr_count, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
